// File: rtl/vcxo_lock_loop.sv
// Frequency-lock loop: counts VCXO ticks over a reference gate window, rejects
// outliers, and steps a saturating, wrap-synchronised PWM duty driving the tuning pump.
module vcxo_lock_loop #(
    parameter int unsigned GATE_CYCLES   = 122880,
    parameter int unsigned NOMINAL_COUNT = 122880,
    parameter int unsigned CNT_W         = 24,
    parameter int unsigned PWM_W         = 12,
    parameter int unsigned PWM_MAX       = 500,
    parameter int unsigned PWM_INIT      = 250,
    parameter int unsigned ERR_LIMIT     = 1000,
    parameter int unsigned JUMP_LIMIT    = 50,
    parameter int unsigned COARSE_THRESH = 64,
    parameter int unsigned COARSE_SHIFT  = 4,
    parameter int unsigned LOCK_TOL      = 2,
    parameter int unsigned LOCK_COUNT    = 8
) (
    input  logic                    clk_in,
    input  logic                    reset_in,
    input  logic                    enable_in,
    input  logic                    hold_in,
    input  logic signed [7:0]       correction_in,
    input  logic                    vcxo_tick_in,
    output logic signed [CNT_W-1:0] freq_error,
    output logic                    freq_error_valid,
    output logic [PWM_W-1:0]        pwm_value,
    output logic                    pump,
    output logic                    locked
);

    localparam int unsigned WIN_W  = $clog2(GATE_CYCLES + 1);
    localparam int unsigned LOCK_W = $clog2(LOCK_COUNT + 1);
    localparam int unsigned SUM_W  = CNT_W + PWM_W + 2;

    localparam logic [WIN_W-1:0]        WIN_LAST   = WIN_W'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0]        NOM        = CNT_W'(NOMINAL_COUNT);
    localparam logic [CNT_W:0]          ERR_LIM_W  = (CNT_W + 1)'(ERR_LIMIT);
    localparam logic [CNT_W:0]          JUMP_LIM_W = (CNT_W + 1)'(JUMP_LIMIT);
    localparam logic [CNT_W:0]          THRESH_W   = (CNT_W + 1)'(COARSE_THRESH);
    localparam logic [CNT_W:0]          TOL_W      = (CNT_W + 1)'(LOCK_TOL);
    localparam logic [LOCK_W-1:0]       LOCK_FULL  = LOCK_W'(LOCK_COUNT);
    localparam logic [PWM_W-1:0]        PWM_LAST   = PWM_W'(PWM_MAX - 1);
    localparam logic [PWM_W-1:0]        PWM_TOP    = PWM_W'(PWM_MAX);
    localparam logic [PWM_W-1:0]        PWM_RST    = PWM_W'(PWM_INIT);
    localparam logic signed [SUM_W-1:0] PWM_TOP_S  = SUM_W'(PWM_MAX);

    typedef enum logic [1:0] {S_IDLE, S_GATE, S_EVAL, S_UPDATE} state_t;

    state_t                  state;
    logic [WIN_W-1:0]        win_cnt;
    logic [CNT_W-1:0]        tick_cnt;
    logic signed [CNT_W-1:0] err_r, prev_error;
    logic [CNT_W:0]          err_abs_r;
    logic                    accept_r, first_window;
    logic [LOCK_W-1:0]       lock_cnt;
    logic [PWM_W-1:0]        shadow, pwm_cnt;

    logic signed [CNT_W-1:0] corr_ext, err_calc;
    logic [CNT_W:0]          err_abs, jump_abs, coarse, step;
    logic                    accept_calc;
    logic signed [SUM_W-1:0] shadow_w, step_w, sum_w;
    logic [PWM_W-1:0]        shadow_next;
    logic [LOCK_W-1:0]       lock_next;

    function automatic logic [CNT_W:0] abs_w(input logic signed [CNT_W:0] v);
        return v[CNT_W] ? $unsigned(-v) : $unsigned(v);
    endfunction

    // Error and jump are evaluated one bit wider so neither magnitude can overflow.
    always_comb begin
        corr_ext    = {{(CNT_W - 8){correction_in[7]}}, correction_in};
        err_calc    = $signed(tick_cnt - NOM + corr_ext);
        err_abs     = abs_w({err_calc[CNT_W-1], err_calc});
        jump_abs    = abs_w({prev_error[CNT_W-1], prev_error} - {err_calc[CNT_W-1], err_calc});
        accept_calc = (err_abs < ERR_LIM_W) && (first_window || (jump_abs < JUMP_LIM_W));
    end

    always_comb begin
        coarse   = err_abs_r >> COARSE_SHIFT;
        step     = ((err_abs_r <= THRESH_W) || (coarse == '0)) ? (CNT_W + 1)'(1) : coarse;
        shadow_w = $signed(SUM_W'(shadow));
        step_w   = $signed(SUM_W'(step));
        if (err_r == '0)
            sum_w = shadow_w;
        else if (err_r[CNT_W-1])
            sum_w = shadow_w + step_w;
        else
            sum_w = shadow_w - step_w;
        if (sum_w[SUM_W-1])
            shadow_next = '0;
        else if (sum_w > PWM_TOP_S)
            shadow_next = PWM_TOP;
        else
            shadow_next = sum_w[PWM_W-1:0];
        if (err_abs_r <= TOL_W)
            lock_next = (lock_cnt == LOCK_FULL) ? lock_cnt : lock_cnt + LOCK_W'(1);
        else
            lock_next = '0;
    end

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            state            <= S_IDLE;
            win_cnt          <= '0;
            tick_cnt         <= '0;
            err_r            <= '0;
            err_abs_r        <= '0;
            accept_r         <= 1'b0;
            prev_error       <= '0;
            first_window     <= 1'b1;
            lock_cnt         <= '0;
            locked           <= 1'b0;
            freq_error       <= '0;
            freq_error_valid <= 1'b0;
            shadow           <= PWM_RST;
            pwm_value        <= PWM_RST;
            pwm_cnt          <= '0;
            pump             <= 1'b0;
        end else begin
            freq_error_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    win_cnt  <= '0;
                    tick_cnt <= '0;
                    if (enable_in)
                        state <= S_GATE;
                end
                S_GATE: begin
                    if (!enable_in) begin
                        state    <= S_IDLE;
                        win_cnt  <= '0;
                        tick_cnt <= '0;
                        lock_cnt <= '0;
                        locked   <= 1'b0;
                    end else begin
                        tick_cnt <= tick_cnt + CNT_W'(vcxo_tick_in);
                        if (win_cnt == WIN_LAST) begin
                            win_cnt <= '0;
                            state   <= S_EVAL;
                        end else begin
                            win_cnt <= win_cnt + WIN_W'(1);
                        end
                    end
                end
                S_EVAL: begin
                    err_r     <= err_calc;
                    err_abs_r <= err_abs;
                    accept_r  <= accept_calc;
                    state     <= S_UPDATE;
                end
                S_UPDATE: begin
                    win_cnt  <= '0;
                    tick_cnt <= '0;
                    if (!enable_in) begin
                        state    <= S_IDLE;
                        lock_cnt <= '0;
                        locked   <= 1'b0;
                    end else begin
                        state        <= S_GATE;
                        prev_error   <= err_r;
                        first_window <= 1'b0;
                        if (accept_r) begin
                            freq_error       <= err_r;
                            freq_error_valid <= 1'b1;
                            lock_cnt         <= lock_next;
                            locked           <= (lock_next == LOCK_FULL);
                            if (!hold_in)
                                shadow <= shadow_next;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase

            // Active duty only follows the shadow at period wrap, so no PWM cycle is truncated.
            if (pwm_cnt == PWM_LAST) begin
                pwm_cnt   <= '0;
                pwm_value <= shadow;
            end else begin
                pwm_cnt <= pwm_cnt + PWM_W'(1);
            end
            pump <= (pwm_value > pwm_cnt);
        end
    end

endmodule

// File: tb/tb_vcxo_lock_loop.sv
// Scoreboard bench for vcxo_lock_loop with small gate/PWM parameters.
module tb_vcxo_lock_loop;

    localparam int GATE  = 100;
    localparam int NOM   = 50;
    localparam int PMAX  = 20;
    localparam int PINIT = 10;
    localparam int LCNT  = 3;
    localparam int JLIM  = 20;
    localparam int ELIM  = 150;
    localparam int CTHR  = 64;
    localparam int CSH   = 4;
    localparam int LTOL  = 2;

    logic               clk_in = 1'b0;
    logic               reset_in, enable_in, hold_in, vcxo_tick_in;
    logic signed [7:0]  correction_in;
    logic signed [23:0] freq_error;
    logic               freq_error_valid, pump, locked;
    logic [11:0]        pwm_value;

    vcxo_lock_loop #(
        .GATE_CYCLES(GATE), .NOMINAL_COUNT(NOM), .CNT_W(24), .PWM_W(12),
        .PWM_MAX(PMAX), .PWM_INIT(PINIT), .ERR_LIMIT(ELIM), .JUMP_LIMIT(JLIM),
        .COARSE_THRESH(CTHR), .COARSE_SHIFT(CSH), .LOCK_TOL(LTOL), .LOCK_COUNT(LCNT)
    ) dut (
        .clk_in(clk_in), .reset_in(reset_in), .enable_in(enable_in), .hold_in(hold_in),
        .correction_in(correction_in), .vcxo_tick_in(vcxo_tick_in),
        .freq_error(freq_error), .freq_error_valid(freq_error_valid),
        .pwm_value(pwm_value), .pump(pump), .locked(locked)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        int err;
        int lck;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   m_prev, m_first, m_lock, m_pwm;

    task automatic check_val(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    always @(negedge clk_in) begin : monitor
        exp_t e;
        if (!reset_in && freq_error_valid) begin
            if (sb_q.size() == 0) begin
                check_val("unexpected_valid", 1, 0);
            end else begin
                e = sb_q.pop_front();
                check_val("freq_error", freq_error, e.err);
                check_val("locked", locked, e.lck);
            end
        end
    end

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    task automatic model_reset();
        m_prev  = 0;
        m_first = 1;
        m_lock  = 0;
        m_pwm   = PINIT;
    endtask

    task automatic start_loop();
        @(negedge clk_in);
        enable_in    = 1'b1;
        vcxo_tick_in = 1'b0;
    endtask

    // Ticks are packed at the end of the gate (so the last gate cycle always carries one);
    // the two dead cycles also carry ticks, which must be ignored.
    task automatic run_window(input int ticks, input int corr, input bit hold);
        int   pcnt, err, aerr, step;
        bit   acc;
        exp_t e;
        pcnt          = 0;
        correction_in = 8'(corr);
        hold_in       = hold;
        for (int i = 0; i < GATE + 2; i++) begin
            @(negedge clk_in);
            if (i == 30) check_val("pwm_value", pwm_value, m_pwm);
            if (i >= 40 && i < 80 && pump) pcnt++;
            vcxo_tick_in = (i >= GATE) ? 1'b1 : (i >= GATE - ticks);
        end
        check_val("pump_duty", pcnt, 2 * m_pwm);

        err  = ticks - NOM + corr;
        aerr = iabs(err);
        acc  = (aerr < ELIM) && (m_first != 0 || iabs(m_prev - err) < JLIM);
        m_prev  = err;
        m_first = 0;
        if (acc) begin
            if (!hold && err != 0) begin
                step = (aerr <= CTHR) ? 1 : (((aerr >> CSH) < 1) ? 1 : (aerr >> CSH));
                m_pwm = (err < 0) ? m_pwm + step : m_pwm - step;
                if (m_pwm > PMAX) m_pwm = PMAX;
                if (m_pwm < 0) m_pwm = 0;
            end
            if (aerr <= LTOL) m_lock = (m_lock < LCNT) ? m_lock + 1 : LCNT;
            else m_lock = 0;
            e.err = err;
            e.lck = (m_lock == LCNT);
            sb_q.push_back(e);
        end
    endtask

    task automatic check_reset_state(input string tag);
        check_val({tag, "_freq_error"}, freq_error, 0);
        check_val({tag, "_valid"}, freq_error_valid, 0);
        check_val({tag, "_pwm_value"}, pwm_value, PINIT);
        check_val({tag, "_pump"}, pump, 0);
        check_val({tag, "_locked"}, locked, 0);
    endtask

    initial begin
        int pcnt;
        reset_in      = 1'b1;
        enable_in     = 1'b0;
        hold_in       = 1'b0;
        correction_in = '0;
        vcxo_tick_in  = 1'b0;
        repeat (3) @(negedge clk_in);
        check_reset_state("rst");
        reset_in = 1'b0;
        model_reset();

        start_loop();
        repeat (4) run_window(50, 0, 0);
        repeat (3) run_window(48, 0, 0);

        run_window(50, 0, 0);
        run_window(80, 0, 0);
        run_window(80, 0, 0);
        run_window(99, 0, 0);
        run_window(79, 0, 0);

        repeat (5) run_window(50, -100, 0);

        run_window(100, 100, 0);
        run_window(100, 99, 0);
        run_window(100, 100, 0);

        repeat (5) run_window(48, 0, 1);

        for (int i = 0; i < 50; i++) begin
            @(negedge clk_in);
            vcxo_tick_in = i[0];
        end
        check_val("locked_before_drop", locked, (m_lock == LCNT) ? 1 : 0);
        enable_in    = 1'b0;
        vcxo_tick_in = 1'b0;
        @(negedge clk_in);
        m_lock = 0;
        check_val("locked_after_drop", locked, 0);
        pcnt = 0;
        for (int i = 0; i < 2 * PMAX; i++) begin
            @(negedge clk_in);
            if (pump) pcnt++;
        end
        check_val("pump_while_idle", pcnt, 2 * m_pwm);

        start_loop();
        run_window(55, -5, 0);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk_in);
            vcxo_tick_in = 1'b1;
        end
        reset_in     = 1'b1;
        enable_in    = 1'b0;
        vcxo_tick_in = 1'b0;
        @(negedge clk_in);
        check_reset_state("midrst");
        reset_in = 1'b0;
        model_reset();

        start_loop();
        run_window(80, 0, 0);
        repeat (5) @(negedge clk_in);
        check_val("pending_expected", sb_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/vcxo_lock_loop.md
Name: vcxo_lock_loop

Overview:
- Single-clock, parametrised frequency-lock loop that disciplines a VCXO against the reference clock.
- Counts pre-synchronised VCXO tick strobes over a fixed gate window of reference cycles and computes a signed frequency error.
- Rejects outliers, then steps a saturating PWM duty using fine (±1) or coarse (proportional) steps, and drives the tuning pump output.
- Adds hold/enable modes, glitch-free shadowed PWM update, and lock detection.

Parameters:
GATE_CYCLES, 122880, clk_in cycles per measurement window
NOMINAL_COUNT, 122880, expected tick count per window at zero error
CNT_W, 24, width of tick counter and error values
PWM_W, 12, width of PWM value/counter
PWM_MAX, 500, PWM period in clk_in cycles; duty range 0..PWM_MAX
PWM_INIT, 250, PWM value after reset
ERR_LIMIT, 1000, reject window if |error| >= ERR_LIMIT
JUMP_LIMIT, 50, reject window if |prev_error - error| >= JUMP_LIMIT
COARSE_THRESH, 64, |error| above this uses coarse step
COARSE_SHIFT, 4, coarse step = |error| >> COARSE_SHIFT, minimum 1
LOCK_TOL, 2, |error| <= LOCK_TOL counts as in-lock
LOCK_COUNT, 8, consecutive in-lock windows required to assert locked

Ports:
clk_in  input  1  reference clock, all logic on rising edge
reset_in  input  1  synchronous reset, active-high
enable_in  input  1  1 = loop runs; 0 = measurement stopped, PWM frozen
hold_in  input  1  1 = measure and report, but do not change PWM
correction_in  input  8 signed  user trim added to error
vcxo_tick_in  input  1  single-cycle strobe per VCXO tick, already synchronised to clk_in
freq_error  output  CNT_W signed  last accepted error
freq_error_valid  output  1  one-cycle pulse when freq_error updates
pwm_value  output  PWM_W  active duty value
pump  output  1  PWM output to tuning filter
locked  output  1  lock indicator

Behaviour:
- Reset values:
  - freq_error=0, freq_error_valid=0, pwm_value=PWM_INIT, shadow=PWM_INIT, pump=0, locked=0.
  - Internal counters 0, prev_error=0, first_window=1, state IDLE.
- Reset asserted mid-window aborts the window and discards all partial counts.
- State IDLE:
  - If enable_in=1, next cycle enter GATE with window and tick counters cleared.
  - Otherwise stay in IDLE.
- State GATE:
  - Window counter counts 0..GATE_CYCLES-1; tick counter increments on each cycle with vcxo_tick_in=1, including the last window cycle.
  - After the last window cycle, go to EVAL.
  - enable_in=0 at any point → IDLE, counts discarded, locked cleared.
- State EVAL (1 cycle):
  - err = ticks - NOMINAL_COUNT + sign_extend(correction_in), computed at CNT_W signed.
  - accept = (|err| < ERR_LIMIT) and (first_window or |prev_error - err| < JUMP_LIMIT).
- State UPDATE (1 cycle):
  - prev_error <= err always; first_window <= 0.
  - If accept:
    - freq_error <= err; freq_error_valid pulses in the cycle after UPDATE.
    - If hold_in=0: step = 1 if |err| <= COARSE_THRESH, else max(1, |err|>>COARSE_SHIFT).
    - err<0: shadow += step; err>0: shadow -= step; err=0: no change.
    - Result saturates to [0, PWM_MAX], computed with enough headroom that no wrap occurs.
  - Lock:
    - On accept with |err| <= LOCK_TOL, the lock counter increments, saturating at LOCK_COUNT.
    - On accept with |err| > LOCK_TOL, the lock counter resets to 0.
    - Rejected windows leave the lock counter unchanged.
    - locked = (lock counter == LOCK_COUNT).
  - Next state: GATE, with counters cleared. Dead time is 2 cycles per window (EVAL, UPDATE); ticks in those cycles are not counted.
- PWM:
  - Free-running counter 0..PWM_MAX-1, wraps to 0; runs regardless of enable_in and hold_in.
  - pwm_value <= shadow only on the cycle the counter wraps to 0, giving glitch-free updates.
  - pump <= (pwm_value > counter), registered.
  - pwm_value=0 → pump always 0; pwm_value=PWM_MAX → pump always 1.
- Simultaneous events:
  - hold_in and enable_in are sampled in UPDATE.
  - enable_in=0 has priority over hold_in.
  - A tick on the last GATE cycle is counted.

Test Plan (sim params GATE_CYCLES=100, NOMINAL_COUNT=50, PWM_MAX=20, PWM_INIT=10, LOCK_COUNT=3):
1. Reset, then enable, tick every 2nd cycle (50 ticks/window) → freq_error=0, pulse each 102 cycles, pwm_value stays 10, locked=1 after the 3rd window.
2. 48 ticks/window → err=-2; shadow 11, 12, 13…; pwm_value changes only at PWM wrap; pump high for exactly pwm_value of every 20 cycles.
3. Window 1 at 50 ticks, then one window at 80 ticks (jump 30 ≥ ... set JUMP_LIMIT=20) → that window rejected: freq_error holds 0, no valid pulse, PWM unchanged; next 80-tick window accepted (prev updated).
4. err=-100 with COARSE_THRESH=64, COARSE_SHIFT=4 → step 6, shadow 10→16; repeated windows saturate at 20 and never wrap.
5. hold_in=1 with err=-2 → valid pulses and freq_error=-2, pwm_value stays 10; enable_in=0 mid-window → IDLE, locked=0, pump continues with last duty.
6. correction_in=-5 with 55 ticks → err=0; reset_in asserted mid-GATE → all outputs return to reset values the next cycle.
